// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared types for the RV32I five-stage pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_unit
// Description : EX operand bypass select; the MEM result wins over WB data.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_unit
    import rv_pipe_pkg::*;
#(
    parameter int RegAddress = 5
) (
    input  logic [RegAddress-1:0] i_ex_rs1,
    input  logic [RegAddress-1:0] i_ex_rs2,
    input  logic [RegAddress-1:0] i_mem_rd,
    input  logic [RegAddress-1:0] i_wb_rd,
    input  logic                  i_mem_wr,
    input  logic                  i_wb_wr,
    output fwd_sel_e              o_fwd_a,
    output fwd_sel_e              o_fwd_b
);

    // i_mem_wr / i_wb_wr already fold in stage validity and rd != x0
    function automatic fwd_sel_e sel_src(input logic [RegAddress-1:0] rs);
        if (i_mem_wr && (i_mem_rd == rs))
            return FWD_MEM;
        else if (i_wb_wr && (i_wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        o_fwd_a = sel_src(i_ex_rs1);
        o_fwd_b = sel_src(i_ex_rs2);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard/sequencing controller for the 5-stage RV32I pipeline.
//               Define PIPELINE_FORWARDING_EN to enable EX operand bypassing.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int RegAddress = 5,
    parameter int MemTimeout = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_instr_valid,
    input  logic [RegAddress-1:0] id_rs1,
    input  logic [RegAddress-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [RegAddress-1:0] ex_rs1,
    input  logic [RegAddress-1:0] ex_rs2,
    input  logic [RegAddress-1:0] ex_rd,
    input  logic [RegAddress-1:0] mem_rd,
    input  logic [RegAddress-1:0] wb_rd,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  ex_load,
    input  logic                  ex_redirect,
    input  logic                  dmem_req,
    input  logic                  dmem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  id_valid,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [DataWidth-1:0]  stall_cycles,
    output logic                  mem_timeout
);

    localparam int                 c_WAIT_W  = $clog2(MemTimeout + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MemTimeout);

    ctrl_state_e          r_state;
    ctrl_state_e          w_state_nxt;
    logic                 r_id_valid;
    logic                 r_ex_valid;
    logic                 r_mem_valid;
    logic                 r_wb_valid;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [c_WAIT_W-1:0]  w_wait_nxt;
    logic [DataWidth-1:0] r_stall_cycles;
    logic                 r_mem_timeout;

    logic     w_ex_wr;
    logic     w_mem_wr;
    logic     w_wb_wr;
    logic     w_ex_hit;
    logic     w_data_stall;
    logic     w_error;
    logic     w_freeze_cond;
    logic     w_freeze;
    logic     w_redirect;
    logic     w_stall;
    fwd_sel_e w_fwd_a;
    fwd_sel_e w_fwd_b;

    // A stage can only be a hazard source if it is live and writes a real register
    assign w_ex_wr  = r_ex_valid  & ex_reg_write  & (ex_rd  != '0);
    assign w_mem_wr = r_mem_valid & mem_reg_write & (mem_rd != '0);
    assign w_wb_wr  = r_wb_valid  & wb_reg_write  & (wb_rd  != '0);

    assign w_ex_hit = w_ex_wr & ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                                 (id_uses_rs2 & (id_rs2 == ex_rd)));

`ifdef PIPELINE_FORWARDING_EN
    assign w_data_stall = r_id_valid & ex_load & w_ex_hit;

    pipe_fwd_unit #(
        .RegAddress (RegAddress)
    ) u_fwd (
        .i_ex_rs1 (ex_rs1),
        .i_ex_rs2 (ex_rs2),
        .i_mem_rd (mem_rd),
        .i_wb_rd  (wb_rd),
        .i_mem_wr (w_mem_wr),
        .i_wb_wr  (w_wb_wr),
        .o_fwd_a  (w_fwd_a),
        .o_fwd_b  (w_fwd_b)
    );
`else
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused;

    // The register file writes at the edge, so a WB producer still blocks decode
    assign w_mem_hit = w_mem_wr & ((id_uses_rs1 & (id_rs1 == mem_rd)) |
                                   (id_uses_rs2 & (id_rs2 == mem_rd)));
    assign w_wb_hit  = w_wb_wr  & ((id_uses_rs1 & (id_rs1 == wb_rd)) |
                                   (id_uses_rs2 & (id_rs2 == wb_rd)));

    assign w_data_stall = r_id_valid & (w_ex_hit | w_mem_hit | w_wb_hit);
    assign w_fwd_a      = FWD_RF;
    assign w_fwd_b      = FWD_RF;
    assign w_unused     = ^{ex_rs1, ex_rs2, ex_load};
`endif

    assign w_error       = (r_state == ERROR);
    assign w_freeze_cond = r_mem_valid & dmem_req & ~dmem_ack;
    assign w_freeze      = ~w_error & w_freeze_cond;
    assign w_redirect    = ~w_error & ~w_freeze & ex_redirect & r_ex_valid;
    assign w_stall       = ~w_error & ~w_freeze & ~w_redirect & w_data_stall;
    assign w_wait_nxt    = r_wait_cnt + c_WAIT_W'(1);

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (w_error) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (w_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (w_freeze_cond) w_state_nxt = MEM_WAIT;
            // A completing ack beats the timeout in the same cycle
            MEM_WAIT: if (!w_freeze_cond)           w_state_nxt = RUN;
                      else if (w_wait_nxt == c_TIMEOUT) w_state_nxt = ERROR;
            ERROR:    w_state_nxt = ERROR;
            default:  w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_timeout <= r_mem_timeout | (w_state_nxt == ERROR);
            if (r_state == MEM_WAIT)
                r_wait_cnt <= w_wait_nxt;
            else if (r_state == RUN)
                r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else if (w_error) begin
            r_id_valid  <= r_id_valid;
        end else if (w_freeze) begin
            r_wb_valid  <= 1'b0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_mem_valid <= r_ex_valid;
            r_ex_valid  <= r_id_valid & ~w_stall & ~w_redirect;
            r_id_valid  <= w_stall ? r_id_valid : (if_instr_valid & ~w_redirect);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (!pc_en && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + DataWidth'(1);
    end

    assign fwd_a        = w_fwd_a;
    assign fwd_b        = w_fwd_b;
    assign id_valid     = r_id_valid;
    assign ex_valid     = r_ex_valid;
    assign mem_valid    = r_mem_valid;
    assign wb_valid     = r_wb_valid;
    assign stall_cycles = r_stall_cycles;
    assign mem_timeout  = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed vector bench for pipeline_ctrl (default and
//               PIPELINE_FORWARDING_EN builds); second instance uses MemTimeout=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

`ifdef PIPELINE_FORWARDING_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       if_instr_valid;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_reg_write, mem_reg_write, wb_reg_write;
    logic       ex_load, ex_redirect, dmem_req, dmem_ack;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        id_valid, ex_valid, mem_valid, wb_valid, mem_timeout;
    logic [31:0] stall_cycles;

    logic        t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_en, t_mem_wb_en;
    logic        t_if_id_flush, t_id_ex_flush;
    logic [1:0]  t_fwd_a, t_fwd_b;
    logic        t_id_valid, t_ex_valid, t_mem_valid, t_wb_valid, t_mem_timeout;
    logic [31:0] t_stall_cycles;

    logic [4:0] en, t_en;
    logic [1:0] fl;
    logic [3:0] vld;
    assign en   = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign t_en = {t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_en, t_mem_wb_en};
    assign fl   = {if_id_flush, id_ex_flush};
    assign vld  = {id_valid, ex_valid, mem_valid, wb_valid};

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .if_instr_valid(if_instr_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .ex_load(ex_load), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid), .stall_cycles(stall_cycles),
        .mem_timeout(mem_timeout)
    );

    pipeline_ctrl #(.MemTimeout(3)) dut_to (
        .clk(clk), .rst(rst), .if_instr_valid(if_instr_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .ex_load(ex_load), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(t_pc_en), .if_id_en(t_if_id_en), .id_ex_en(t_id_ex_en), .ex_mem_en(t_ex_mem_en),
        .mem_wb_en(t_mem_wb_en), .if_id_flush(t_if_id_flush), .id_ex_flush(t_id_ex_flush),
        .fwd_a(t_fwd_a), .fwd_b(t_fwd_b), .id_valid(t_id_valid), .ex_valid(t_ex_valid),
        .mem_valid(t_mem_valid), .wb_valid(t_wb_valid), .stall_cycles(t_stall_cycles),
        .mem_timeout(t_mem_timeout)
    );

    typedef struct {
        string      name;
        logic [4:0] id_rs1, id_rs2;
        logic       u1, u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic       ex_rw, mem_rw, wb_rw, ld, redir, req, ack;
        logic [4:0] f_en;
        logic [1:0] f_fl, fa, fb;
        logic [4:0] n_en;
        logic [1:0] n_fl;
    } vec_t;

    vec_t        vt[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] s0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic neutral();
        if_instr_valid = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        ex_load = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; mem_rd = v.mem_rd; wb_rd = v.wb_rd;
        ex_reg_write = v.ex_rw; mem_reg_write = v.mem_rw; wb_reg_write = v.wb_rw;
        ex_load = v.ld; ex_redirect = v.redir; dmem_req = v.req; dmem_ack = v.ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        neutral();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic refill();
        repeat (5) begin
            @(negedge clk);
            neutral();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        //            name            r1 r2 u1 u2 xr1 xr2 xrd mrd wrd xw mw ww ld rd rq ak  f_en      f_fl   fa     fb     n_en      n_fl
        vt.push_back('{"idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 5'b11111, 2'b00});
        vt.push_back('{"ld_use_rs1",   5, 1, 1, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b00111, 2'b01, 2'b00, 2'b00, 5'b00111, 2'b01});
        vt.push_back('{"ld_use_rs2",   2, 6, 1, 1, 0, 0, 6, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b00111, 2'b01, 2'b00, 2'b00, 5'b00111, 2'b01});
        vt.push_back('{"ld_src_unused",5, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 5'b11111, 2'b00});
        vt.push_back('{"alu_ex_hit",   5, 0, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 5'b00111, 2'b01});
        vt.push_back('{"mem_wb_x5",    0, 0, 0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b01, 2'b00, 5'b11111, 2'b00});
        vt.push_back('{"wb_only_rs2",  0, 0, 0, 0, 0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b10, 5'b11111, 2'b00});
        vt.push_back('{"mem_both",     0, 0, 0, 0, 3, 3, 0, 3, 3, 0, 1, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b01, 2'b01, 5'b11111, 2'b00});
        vt.push_back('{"mem_nowrite",  0, 0, 0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b10, 2'b00, 5'b11111, 2'b00});
        vt.push_back('{"x0_writer",    0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 5'b11111, 2'b00});
        vt.push_back('{"wb_hit_dec",   0, 9, 0, 1, 0, 9, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b10, 5'b00111, 2'b01});
        vt.push_back('{"redir_ld_use", 5, 1, 1, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 0, 0, 5'b11111, 2'b11, 2'b00, 2'b00, 5'b11111, 2'b11});
        vt.push_back('{"redirect",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 2'b11, 2'b00, 2'b00, 5'b11111, 2'b11});
        vt.push_back('{"freeze",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 5'b00001, 2'b00});
        vt.push_back('{"req_ack",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 5'b11111, 2'b00});
        vt.push_back('{"freeze_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 5'b00001, 2'b00});
        vt.push_back('{"freeze_lduse", 5, 1, 1, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 1, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 5'b00001, 2'b00});

        // Reset state
        rst = 1'b1;
        neutral();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(vld), 32'h0);
        chk("rst_en", 32'(en), 32'h1f);
        chk("rst_flush", 32'(fl), 32'h0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        chk("rst_stall_cnt", stall_cycles, 32'h0);
        chk("rst_timeout", 32'({mem_timeout, t_mem_timeout}), 32'h0);
        rst = 1'b0;

        refill();
        @(negedge clk);
        #1;
        chk("fill_valid", 32'(vld), 32'hf);

        // Combinational vectors: applied and withdrawn between clock edges
        foreach (vt[i]) begin
            @(negedge clk);
            neutral();
            apply_vec(vt[i]);
            #1;
            chk({vt[i].name, "_en"},    32'(en), 32'(c_FWD ? vt[i].f_en : vt[i].n_en));
            chk({vt[i].name, "_flush"}, 32'(fl), 32'(c_FWD ? vt[i].f_fl : vt[i].n_fl));
            chk({vt[i].name, "_fwd_a"}, 32'(fwd_a), 32'(c_FWD ? vt[i].fa : 2'b00));
            chk({vt[i].name, "_fwd_b"}, 32'(fwd_b), 32'(c_FWD ? vt[i].fb : 2'b00));
            #1;
            neutral();
        end

        // lw x5 in EX, add x6,x5,x1 in decode
        @(negedge clk); neutral();
        id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 1; id_uses_rs2 = 1;
        ex_rd = 5; ex_reg_write = 1; ex_load = 1;
        #1;
        s0 = stall_cycles;
        chk("lu1_pc_en", 32'(pc_en), 32'h0);
        chk("lu1_id_ex_flush", 32'(id_ex_flush), 32'h1);
        @(negedge clk); neutral();
        id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 1; id_uses_rs2 = 1;
        mem_rd = 5; mem_reg_write = 1;
        #1;
        chk("lu2_pc_en", 32'(pc_en), c_FWD ? 32'h1 : 32'h0);
        chk("lu2_ex_bubble", 32'(ex_valid), 32'h0);
        @(negedge clk); neutral();
        id_rs1 = 5; id_uses_rs1 = 1;
        ex_rs1 = 5; ex_rd = 6; ex_reg_write = 1;
        wb_rd = 5; wb_reg_write = 1;
        #1;
        chk("lu3_pc_en", 32'(pc_en), c_FWD ? 32'h1 : 32'h0);
        chk("lu3_ex_valid", 32'(ex_valid), c_FWD ? 32'h1 : 32'h0);
        chk("lu3_fwd_a", 32'(fwd_a), c_FWD ? 32'h2 : 32'h0);
        @(negedge clk); neutral();
        id_rs1 = 5; id_uses_rs1 = 1;
        #1;
        chk("lu4_pc_en", 32'(pc_en), 32'h1);
        @(negedge clk); neutral();
        #1;
        chk("lu_stall_delta", stall_cycles - s0, c_FWD ? 32'd1 : 32'd3);

        // Redirect squashes ID and EX
        refill();
        @(negedge clk); neutral();
        ex_redirect = 1;
        #1;
        chk("redir_flush", 32'(fl), 32'h3);
        chk("redir_en", 32'(en), 32'h1f);
        @(negedge clk); neutral();
        #1;
        chk("redir_valid_after", 32'({id_valid, ex_valid, mem_valid}), 32'h1);

        // Data memory ack delayed four cycles
        refill();
        @(negedge clk); neutral();
        dmem_req = 1;
        #1;
        s0 = stall_cycles;
        chk("dm0_en", 32'(en), 32'h01);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); neutral();
            dmem_req = 1;
            #1;
            chk($sformatf("dm%0d_pc_en", k), 32'(pc_en), 32'h0);
            chk($sformatf("dm%0d_wb_valid", k), 32'(wb_valid), 32'h0);
            chk($sformatf("dm%0d_mem_valid", k), 32'(mem_valid), 32'h1);
        end
        @(negedge clk); neutral();
        dmem_req = 1; dmem_ack = 1;
        #1;
        chk("dm4_ack_pc_en", 32'(pc_en), 32'h1);
        @(negedge clk); neutral();
        #1;
        chk("dm_stall_delta", stall_cycles - s0, 32'd4);

        // MemTimeout = 3 with no ack reaches ERROR
        do_reset();
        refill();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); neutral();
            dmem_req = 1;
            #1;
            if (k == 0) chk("to0_pc_en", 32'(t_pc_en), 32'h0);
            if (k == 3) chk("to3_timeout", 32'(t_mem_timeout), 32'h0);
        end
        @(negedge clk); neutral();
        dmem_req = 1;
        #1;
        chk("to4_timeout", 32'(t_mem_timeout), 32'h1);
        chk("to4_en", 32'(t_en), 32'h0);
        @(negedge clk); neutral();
        #1;
        chk("to5_en_sticky", 32'(t_en), 32'h0);
        do_reset();
        chk("to_rst_timeout", 32'(t_mem_timeout), 32'h0);
        chk("to_rst_en", 32'(t_en), 32'h1f);

        // Ack arriving on the cycle the counter hits MemTimeout wins
        refill();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); neutral();
            dmem_req = 1;
            dmem_ack = (k == 3);
        end
        @(negedge clk); neutral();
        #1;
        chk("ackwin_timeout", 32'(t_mem_timeout), 32'h0);
        chk("ackwin_pc_en", 32'(t_pc_en), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
